// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit with MTHI/MTLO write path.
// Define MULT_DIV_FAST_MULT_EN for a single-cycle combinational multiply.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count;
    logic               dz_flag;
    logic               neg_q, neg_r;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic               accept, is_mult, is_signed, b_zero;
    logic               mul_last, div_last;
    logic [2*WIDTH-1:0] mul_step, mul_prod, div_nxt;
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH:0]     div_diff;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign accept    = start && (state == IDLE || state == FIN) && (alu_control[3:2] == 2'b10);
    assign is_mult   = alu_control[1];
    assign is_signed = ~alu_control[0];
    assign b_zero    = (op_b == '0);

    // Restoring divide step: acc holds {remainder, remaining dividend bits}.
    assign div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = (div_part >= {1'b0, opnd});
    assign div_diff = div_part - {1'b0, opnd};
    assign div_nxt  = {(div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]),
                       acc[WIDTH-2:0], div_ge};
    assign div_last = (state == DIV) && (count == CW'(1));

`ifdef MULT_DIV_FAST_MULT_EN
    assign mul_step = acc;
    assign mul_prod = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
    assign mul_last = (state == MUL);
`else
    // Shift-add step: multiplier bits shift out of the low half as product bits shift in.
    logic [WIDTH:0] mul_sum;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};
    assign mul_prod = mul_step;
    assign mul_last = (state == MUL) && (count == CW'(1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            dz_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                count   <= CW'(WIDTH);
                dz_flag <= !is_mult && b_zero;
            end else if (busy) begin
                count <= count - CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN: begin
                if (accept)
                    state_nxt = is_mult ? MUL : (b_zero ? FIN : DIV);
                else
                    state_nxt = IDLE;
            end
            MUL:     if (mul_last) state_nxt = FIN;
            DIV:     if (div_last) state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == MUL) || (state == DIV);
        done        = (state == FIN);
        div_by_zero = (state == FIN) && dz_flag;
    end

    // Operand capture and iteration; datapath needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            neg_q <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_r <= is_signed && op_a[WIDTH-1];
            if (is_mult) begin
                opnd <= mag(op_a, is_signed);
                acc  <= {{WIDTH{1'b0}}, mag(op_b, is_signed)};
            end else begin
                opnd <= mag(op_b, is_signed);
                acc  <= {{WIDTH{1'b0}}, mag(op_a, is_signed)};
            end
        end else if (state == MUL) begin
            acc <= mul_step;
        end else if (state == DIV) begin
            acc <= div_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_last) begin
            {hi, lo} <= neg_if2(mul_prod, neg_q);
        end else if (div_last) begin
            hi <= neg_if(div_nxt[2*WIDTH-1:WIDTH], neg_r);
            lo <= neg_if(div_nxt[WIDTH-1:0], neg_q);
        end else if ((state == IDLE || state == FIN) && !accept) begin
            if (mthi_en) hi <= write_data;
            if (mtlo_en) lo <= write_data;
        end
    end

endmodule
